dac_spi: RTL and testbench
==========================

# dac_spi

Serial transmitter for the LTC2624 quad DAC. It accepts a parallel word from the DAC control stage: 12-bit `data`, 4-bit `address`, 4-bit `command` and a `dactrig` request. It serialises that word into one 32-bit SPI frame on `SPI_SCK`/`SPI_MOSI`/`DAC_CS` and reports completion back to the control stage on `dacdone`. The block sits directly between the control stage and the board's DAC pins.

## Interface

- `HALF`, default 2: SCK half-period in `CLK50MHZ` cycles; legal range ≥1. The default gives SCK = 12.5 MHz.
- `CLK50MHZ` input, 1 bit: system clock, 50 MHz. This is the only clock.
- `RST` input, 1 bit: reset, synchronous, active-high.
- `data` input, 12 bits: DAC code, sampled at frame start.
- `address` input, 4 bits: DAC channel select (4'hF = all channels), sampled at frame start.
- `command` input, 4 bits: LTC2624 command (4'h3 = write and update), sampled at frame start.
- `dactrig` input, 1 bit: frame request; level-sensitive and sampled only in IDLE.
- `dacdone` output, 1 bit: one-cycle pulse when a frame completes.
- `busy` output, 1 bit: high from frame start through the end of the CS-high gap.
- `SPI_SCK` output, 1 bit: serial clock; idles low.
- `SPI_MOSI` output, 1 bit: serial data, MSB first.
- `DAC_CS` output, 1 bit: chip select, active-low.
- `DAC_CLR` output, 1 bit: DAC asynchronous clear, active-low.

## Operation

- **Frame format.** The 32-bit frame is {8'h00, command, address, data, 4'h0}, shifted MSB first. The LTC2624 samples `SPI_MOSI` on the rising edge of `SPI_SCK`.
- **Outputs during reset** (all registered):
  - `SPI_SCK` = 0, `SPI_MOSI` = 0, `DAC_CS` = 1, `DAC_CLR` = 0
  - `dacdone` = 0, `busy` = 0
- **Outputs after reset.** `DAC_CLR` = 1 from the first cycle after `RST` falls.
- **State machine.** The FSM has three states: IDLE, SHIFT and GAP.
  - IDLE → SHIFT when `dactrig` = 1 is sampled. On that transition:
    - `data`, `address` and `command` are latched into a 32-bit shift register.
    - `DAC_CS` goes to 0, `busy` goes to 1, and `SPI_MOSI` takes frame bit 31.
  - SHIFT: a divider counter (0..HALF-1) and a 5-bit bit counter (0..31) run.
    - `SPI_SCK` is low for HALF cycles, then high for HALF cycles, per bit.
    - `SPI_MOSI` changes only on the cycle `SPI_SCK` returns low, never while it is high.
  - SHIFT → GAP after the 32nd high phase. On that transition:
    - `SPI_SCK` = 0, `DAC_CS` = 1 and `SPI_MOSI` = 0.
    - `dacdone` = 1 for exactly one cycle.
  - GAP lasts 2·HALF cycles with `DAC_CS` high; this is the minimum CS-high time. GAP → IDLE afterwards, and `busy` = 0 in IDLE.
- **Input handling.**
  - Input changes on `data`, `address` or `command` after frame start are ignored until the next frame.
  - `dactrig` is ignored in SHIFT and GAP; no request is queued.
  - If `dactrig` stays high, a new frame starts on the first IDLE cycle, which gives back-to-back frames.
- **Reset mid-frame.** `RST` in any state puts all outputs at their reset values on the next edge. The frame is aborted and no `dacdone` pulse is produced.
- **Simultaneous `RST` and `dactrig`.** `RST` wins.

## Timing

- **Frame latency.** T is the IDLE cycle in which `dactrig` = 1 is sampled.
  - `DAC_CS` is low over cycles T+1 … T+64·HALF.
  - `DAC_CS` is high and `dacdone` = 1 at T+64·HALF+1.
  - With HALF = 2, `DAC_CS` is low for T+1 … T+128 and `dacdone` pulses at T+129.
- **GAP and restart.**
  - GAP occupies T+64·HALF+1 … T+64·HALF+2·HALF.
  - IDLE is reached at T+66·HALF+1, the earliest cycle a new request can be sampled.
  - The next `DAC_CS` falling edge is one cycle after that.
- **Repeat period.** Continuous `dactrig` gives a repeat period of 66·HALF+1 cycles (133 at HALF = 2).
- **Bit timing.**
  - For bit k (k = 0 for the MSB), `SPI_SCK` rises at T+1+(2k+1)·HALF and falls at T+1+(2k+2)·HALF.
  - MOSI setup and hold around each rising edge is HALF cycles each.

## Test plan

- **Reset values.** Hold `RST` for 3 cycles with `dactrig` = 1 → `SCK`=0, `MOSI`=0, `CS`=1, `CLR`=0, `dacdone`=0, `busy`=0 throughout; `CLR`=1 on the cycle after release.
- **Single frame.** `data`=12'hABC, `address`=4'hF, `command`=4'h3, 1-cycle `dactrig` (HALF=2) → the bench's DAC model captures 32'h003FABC0 on SCK rising edges; `CS` is low for exactly 128 cycles; `dacdone` is a single pulse at T+129; `busy` falls at T+133.
- **Inputs ignored mid-frame.** Change `data` to 12'h123 at bit 12 of a 12'hFFF frame → the captured frame is 32'h003FFFF0; the following frame carries 12'h123.
- **Back-to-back frames.** Hold `dactrig` high for 3 frames → three frames; `CS` is high for exactly 5 cycles between frames; repeat period is 133 cycles; one `dacdone` per frame.
- **Reset mid-frame.** Assert `RST` after the 10th SCK rising edge → `CS`=1 and `SCK`=0 the next cycle; no `dacdone`. A subsequent request with 12'h800 captures a complete 32'h003F8000.
- **Minimum divider.** HALF=1, `data`=12'h001 → SCK period of 2 cycles; `CS` low for 64 cycles; captured frame 32'h003F0010.

Source files
------------

// File: rtl/dac_spi_if.sv
// Control-side handshake between the DAC control stage and the LTC2624
// serial transmitter: parallel DAC word, frame request and completion/busy
// status.
interface dac_spi_if;
  logic [11:0] data;
  logic [3:0]  address;
  logic [3:0]  command;
  logic        dactrig;
  logic        dacdone;
  logic        busy;

  modport master (
    output data, address, command, dactrig,
    input  dacdone, busy
  );

  modport slave (
    input  data, address, command, dactrig,
    output dacdone, busy
  );
endinterface

// File: rtl/dac_spi.sv
// LTC2624 SPI transmitter. Serialises {8'h00, command, address, data, 4'h0}
// MSB first with SCK idling low. MOSI only changes as SCK returns low, so the
// DAC (which samples on SCK rising) sees HALF cycles of setup and hold.
// After 32 bits CS is raised for at least 2*HALF cycles before the next
// request is accepted.
module dac_spi #(
  parameter int HALF = 2
) (
  input  logic    CLK50MHZ,
  input  logic    RST,
  dac_spi_if.slave bus,
  output logic    SPI_SCK,
  output logic    SPI_MOSI,
  output logic    DAC_CS,
  output logic    DAC_CLR
);

  // Counter is shared by the SCK divider (0..HALF-1) and the CS-high gap
  // (0..2*HALF-1), so it is sized for the larger of the two.
  localparam int CW = $clog2(2 * HALF) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] div;
  logic [4:0]    bitcnt;
  logic [31:0]   shreg;
  logic [31:0]   frame_in;
  logic          done_r;
  logic          busy_r;
  logic          start;
  logic          sck_fall;

  function automatic logic [31:0] build_frame(input logic [3:0]  cmd,
                                              input logic [3:0]  adr,
                                              input logic [11:0] code);
    return {8'h00, cmd, adr, code, 4'h0};
  endfunction

  assign frame_in    = build_frame(bus.command, bus.address, bus.data);
  assign start       = (state == IDLE) && bus.dactrig;
  // End of a high phase that is not the last bit: next bit goes onto MOSI.
  assign sck_fall    = (state == SHIFT) && (div == DIV_LAST) && SPI_SCK &&
                       (bitcnt != 5'd31);
  assign bus.dacdone = done_r;
  assign bus.busy    = busy_r;

  // Frame sequencer: IDLE waits for a request, SHIFT generates SCK and
  // advances MOSI, GAP holds CS high for the minimum CS-high time.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state    <= IDLE;
      div      <= '0;
      bitcnt   <= '0;
      SPI_SCK  <= 1'b0;
      SPI_MOSI <= 1'b0;
      DAC_CS   <= 1'b1;
      DAC_CLR  <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      DAC_CLR <= 1'b1;
      done_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.dactrig) begin
            state    <= SHIFT;
            div      <= '0;
            bitcnt   <= '0;
            SPI_SCK  <= 1'b0;
            DAC_CS   <= 1'b0;
            busy_r   <= 1'b1;
            SPI_MOSI <= frame_in[31];
          end
        end
        SHIFT: begin
          if (div == DIV_LAST) begin
            div <= '0;
            if (!SPI_SCK) begin
              SPI_SCK <= 1'b1;
            end else begin
              SPI_SCK <= 1'b0;
              if (bitcnt == 5'd31) begin
                state    <= GAP;
                DAC_CS   <= 1'b1;
                SPI_MOSI <= 1'b0;
                done_r   <= 1'b1;
              end else begin
                bitcnt   <= bitcnt + 5'd1;
                SPI_MOSI <= shreg[31];
              end
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        GAP: begin
          if (div == GAP_LAST) begin
            state  <= IDLE;
            div    <= '0;
            busy_r <= 1'b0;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Remaining frame bits, already aligned so bit 31 is the next MOSI value;
  // loaded only at frame start so later input changes are ignored.
  always_ff @(posedge CLK50MHZ) begin
    if (start) begin
      shreg <= {frame_in[30:0], 1'b0};
    end else if (sck_fall) begin
      shreg <= {shreg[30:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_dac_spi.sv
// Bench for dac_spi: one instance at HALF=2 and one at HALF=1, a DAC pin
// monitor that captures MOSI on SCK rising edges and logs event cycles, and
// a frame/timing reference computed from the frame rules.
module tb_dac_spi;
  localparam int H0 = 2;
  localparam int H1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pc  = 0;
  int   ntests = 0;
  int   nfail  = 0;

  logic [1:0] sck_w, mosi_w, cs_w, clr_w, done_w, busy_w;

  dac_spi_if bus0();
  dac_spi_if bus1();

  dac_spi #(.HALF(H0)) dut0 (
    .CLK50MHZ(clk), .RST(rst), .bus(bus0.slave),
    .SPI_SCK(sck_w[0]), .SPI_MOSI(mosi_w[0]), .DAC_CS(cs_w[0]), .DAC_CLR(clr_w[0])
  );
  dac_spi #(.HALF(H1)) dut1 (
    .CLK50MHZ(clk), .RST(rst), .bus(bus1.slave),
    .SPI_SCK(sck_w[1]), .SPI_MOSI(mosi_w[1]), .DAC_CS(cs_w[1]), .DAC_CLR(clr_w[1])
  );

  assign done_w = {bus1.dacdone, bus0.dacdone};
  assign busy_w = {bus1.busy, bus0.busy};

  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 1;

  // DAC pin monitor (one observation per cycle, on the falling clock edge)
  logic [1:0]  p_cs = 2'b11, p_sck = 2'b00, p_mosi = 2'b00, p_busy = 2'b00;
  logic [31:0] shf [2];
  int nbits [2];
  int frst [2];
  int lst [2];
  int viol [2];
  int nfall [2], nrise [2], ndone [2], nbf [2];
  int fall_log [2][64];
  int rise_log [2][64];
  int done_log [2][64];
  int bf_log [2][64];
  int bits_log [2][64];
  int first_log [2][64];
  int last_log [2][64];
  logic [31:0] frm_log [2][64];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (p_cs[i] && !cs_w[i]) begin
        if (nfall[i] < 64) fall_log[i][nfall[i]] <= pc;
        nfall[i] <= nfall[i] + 1;
        nbits[i] <= 0;
        shf[i]   <= '0;
      end
      if (!cs_w[i] && !p_sck[i] && sck_w[i]) begin
        shf[i] <= {shf[i][30:0], mosi_w[i]};
        if (nbits[i] == 0) frst[i] <= pc;
        lst[i]   <= pc;
        nbits[i] <= nbits[i] + 1;
      end
      if (p_sck[i] && sck_w[i] && (mosi_w[i] != p_mosi[i])) viol[i] <= viol[i] + 1;
      if (!p_cs[i] && cs_w[i]) begin
        if (nrise[i] < 64) begin
          rise_log[i][nrise[i]]  <= pc;
          frm_log[i][nrise[i]]   <= shf[i];
          bits_log[i][nrise[i]]  <= nbits[i];
          first_log[i][nrise[i]] <= frst[i];
          last_log[i][nrise[i]]  <= lst[i];
        end
        nrise[i] <= nrise[i] + 1;
      end
      if (done_w[i]) begin
        if (ndone[i] < 64) done_log[i][ndone[i]] <= pc;
        ndone[i] <= ndone[i] + 1;
      end
      if (p_busy[i] && !busy_w[i]) begin
        if (nbf[i] < 64) bf_log[i][nbf[i]] <= pc;
        nbf[i] <= nbf[i] + 1;
      end
    end
    p_cs   <= cs_w;
    p_sck  <= sck_w;
    p_mosi <= mosi_w;
    p_busy <= busy_w;
  end

  function automatic logic [31:0] model_frame(input logic [3:0] c, input logic [3:0] a,
                                              input logic [11:0] d);
    return (32'(c) << 20) | (32'(a) << 16) | (32'(d) << 4);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic [11:0] d, input logic [3:0] a,
                        input logic [3:0] c);
    if (i == 0) begin bus0.data = d; bus0.address = a; bus0.command = c; end
    else        begin bus1.data = d; bus1.address = a; bus1.command = c; end
  endtask

  task automatic set_trig(input int i, input logic v);
    if (i == 0) bus0.dactrig = v;
    else        bus1.dactrig = v;
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 400 && busy_w[i]; k++) tick();
    chk($sformatf("idle_wait_i%0d", i), busy_w[i], 1'b0);
  endtask

  // One frame on instance i with all timing checks; optionally changes data
  // after bit chg_bit has been clocked into the DAC.
  task automatic run_frame(input int i, input logic [11:0] d, input logic [3:0] a,
                           input logic [3:0] c, input logic [31:0] exp,
                           input int chg_bit, input logic [11:0] chg_d);
    int h, t, bf0, nf0, nr0, nd0;
    h = (i == 0) ? H0 : H1;
    wait_idle(i);
    bf0 = nbf[i]; nf0 = nfall[i]; nr0 = nrise[i]; nd0 = ndone[i];
    set_in(i, d, a, c);
    set_trig(i, 1'b1);
    t = pc;
    tick();
    set_trig(i, 1'b0);
    if (chg_bit >= 0) begin
      for (int k = 0; k < 200 && nbits[i] != chg_bit; k++) tick();
      chk("chg_wait", nbits[i], chg_bit);
      set_in(i, chg_d, a, c);
    end
    for (int k = 0; k < 80 * h + 40 && nbf[i] <= bf0; k++) tick();
    chk($sformatf("frame_end_i%0d", i), nbf[i] - bf0, 1);
    chk($sformatf("frame_i%0d", i), frm_log[i][nr0], exp);
    chk("frame_bits", bits_log[i][nr0], 32);
    chk("cs_fall_lat", fall_log[i][nf0] - t, 1);
    chk("cs_low_len", rise_log[i][nr0] - fall_log[i][nf0], 64 * h);
    chk("done_count", ndone[i] - nd0, 1);
    chk("done_lat", done_log[i][nd0] - t, 64 * h + 1);
    chk("busy_fall_lat", bf_log[i][bf0] - t, 66 * h + 1);
    chk("first_rise_lat", first_log[i][nr0] - t, 1 + h);
    chk("sck_span", last_log[i][nr0] - first_log[i][nr0], 62 * h);
  endtask

  typedef struct {
    int          inst;
    logic [11:0] d;
    logic [3:0]  a;
    logic [3:0]  c;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t vt [7];
    logic [31:0] ex;
    int t, bf0, nf0, nr0, nd0, ii;
    logic [11:0] rd;
    logic [3:0]  ra, rc;

    vt[0] = '{0, 12'hABC, 4'hF, 4'h3, 32'h003FABC0};
    vt[1] = '{0, 12'hFFF, 4'hF, 4'h3, 32'h003FFFF0};
    vt[2] = '{0, 12'h000, 4'h0, 4'h0, 32'h00000000};
    vt[3] = '{0, 12'h555, 4'h1, 4'hA, 32'h00A15550};
    vt[4] = '{0, 12'hFFF, 4'hF, 4'hF, 32'h00FFFFF0};
    vt[5] = '{1, 12'h001, 4'hF, 4'h3, 32'h003F0010};
    vt[6] = '{1, 12'hA5A, 4'h2, 4'h3, 32'h0032A5A0};

    set_in(0, 12'hABC, 4'hF, 4'h3);
    set_in(1, 12'h000, 4'h0, 4'h0);
    set_trig(0, 1'b1);
    set_trig(1, 1'b0);

    // Reset held with a pending request: everything stays at reset values
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int i = 0; i < 2; i++)
        chk($sformatf("rst_hold%0d_i%0d", k, i),
            {sck_w[i], mosi_w[i], cs_w[i], clr_w[i], done_w[i], busy_w[i]}, 6'b001000);
    end
    set_trig(0, 1'b0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 2; i++)
      chk($sformatf("clr_after_rst_i%0d", i), {clr_w[i], cs_w[i], busy_w[i]}, 3'b110);

    // Table-driven frames
    for (int n = 0; n < 7; n++)
      run_frame(vt[n].inst, vt[n].d, vt[n].a, vt[n].c, vt[n].exp, -1, 12'h000);

    // Data change during a frame is ignored, then carried by the next frame
    run_frame(0, 12'hFFF, 4'hF, 4'h3, 32'h003FFFF0, 12, 12'h123);
    run_frame(0, 12'h123, 4'hF, 4'h3, 32'h003F1230, -1, 12'h000);

    // Back-to-back frames with dactrig held high
    wait_idle(0);
    bf0 = nbf[0]; nf0 = nfall[0]; nr0 = nrise[0]; nd0 = ndone[0];
    set_in(0, 12'h5A5, 4'hF, 4'h3);
    set_trig(0, 1'b1);
    t = pc;
    for (int k = 0; k < 600 && nfall[0] < nf0 + 3; k++) tick();
    set_trig(0, 1'b0);
    chk("b2b_starts", nfall[0] - nf0, 3);
    for (int k = 0; k < 300 && nbf[0] < bf0 + 3; k++) tick();
    chk("b2b_ends", nbf[0] - bf0, 3);
    chk("b2b_first_fall", fall_log[0][nf0] - t, 1);
    chk("b2b_dones", ndone[0] - nd0, 3);
    for (int k = 1; k < 3; k++) begin
      chk($sformatf("b2b_period%0d", k), fall_log[0][nf0 + k] - fall_log[0][nf0 + k - 1], 133);
      chk($sformatf("b2b_cs_high%0d", k), fall_log[0][nf0 + k] - rise_log[0][nr0 + k - 1], 5);
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("b2b_frame%0d", k), frm_log[0][nr0 + k], 32'h003F5A50);

    // Reset after the 10th SCK rising edge aborts the frame silently
    wait_idle(0);
    nd0 = ndone[0];
    set_in(0, 12'hAAA, 4'hF, 4'h3);
    set_trig(0, 1'b1);
    tick();
    set_trig(0, 1'b0);
    for (int k = 0; k < 300 && nbits[0] != 10; k++) tick();
    chk("rst_mid_bit10", nbits[0], 10);
    rst = 1'b1;
    tick();
    chk("rst_mid_outs", {cs_w[0], sck_w[0], busy_w[0], done_w[0]}, 4'b1000);
    rst = 1'b0;
    for (int k = 0; k < 140; k++) tick();
    chk("rst_mid_no_done", ndone[0] - nd0, 0);
    run_frame(0, 12'h800, 4'hF, 4'h3, 32'h003F8000, -1, 12'h000);

    // Randomised frames on either instance against the frame model
    for (int n = 0; n < 8; n++) begin
      ii = int'($urandom_range(0, 1));
      rd = 12'($urandom_range(0, 4095));
      ra = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      ex = model_frame(rc, ra, rd);
      run_frame(ii, rd, ra, rc, ex, -1, 12'h000);
    end

    chk("mosi_stable_hi_i0", viol[0], 0);
    chk("mosi_stable_hi_i1", viol[1], 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
